// File: rtl/psg_ay38910_core.sv
// AY-3-8910/8913-compatible PSG core: bus-decoded register file, tone/noise/envelope
// generators, log attenuation, saturating mixer and PWM master output.
`timescale 1ns/1ps
module psg_ay38910_core #(
  parameter logic [3:0] DA7_DA4_UPPER_ADDRESS_MASK = 4'b0000,
  parameter int NUM_CHANNELS        = 3,
  parameter int CLOCK_DIV           = 8,
  parameter int ENVELOPE_BITS       = 4,
  parameter int CHANNEL_OUTPUT_BITS = 8,
  parameter int MASTER_OUTPUT_BITS  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    data,
  input  logic                          bdir,
  input  logic                          bc1,
  output logic [MASTER_OUTPUT_BITS-1:0] master,
  output logic                          pwm_out
);
  localparam int EB = ENVELOPE_BITS;
  localparam int COB = CHANNEL_OUTPUT_BITS;
  localparam int MOB = MASTER_OUTPUT_BITS;
  localparam int SW = COB + 2;
  localparam int PW = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;
  localparam logic [EB-1:0] ENV_MAX = '1;
  localparam logic [COB-1:0] FULL = '1;

  typedef enum logic {ENV_RUN, ENV_HOLD} env_state_e;

  logic [3:0] addr_q;
  logic [7:0] regs_q [16];
  logic       env_restart_q;

  // Bus decode: a latch (BDIR+BC1) only takes when DA7..DA4 match the chip-select mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q        <= '0;
      env_restart_q <= 1'b0;
      for (int r = 0; r < 16; r++) regs_q[r] <= '0;
    end else begin
      env_restart_q <= 1'b0;
      if (bdir && bc1 && data[7:4] == DA7_DA4_UPPER_ADDRESS_MASK) begin
        addr_q <= data[3:0];
      end else if (bdir && !bc1 && addr_q < 4'd14) begin
        regs_q[addr_q] <= data;
        env_restart_q  <= (addr_q == 4'd13);
      end
    end
  end

  logic [PW-1:0] presc_q;
  logic          tick;
  assign tick = (presc_q == PW'(CLOCK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= tick ? '0 : presc_q + PW'(1);
  end

  // Noise: 5-bit period counter clocking a 17-bit LFSR.
  logic [4:0]  nz_cnt_q, nz_pm1;
  logic [16:0] lfsr_q;
  logic        noise;
  assign nz_pm1 = (regs_q[6][4:0] == 5'd0) ? 5'd0 : regs_q[6][4:0] - 5'd1;
  assign noise  = lfsr_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nz_cnt_q <= '0;
      lfsr_q   <= 17'h1;
    end else if (tick) begin
      if (nz_cnt_q >= nz_pm1) begin
        nz_cnt_q <= '0;
        lfsr_q   <= {lfsr_q[0] ^ lfsr_q[3], lfsr_q[16:1]};
      end else begin
        nz_cnt_q <= nz_cnt_q + 5'd1;
      end
    end
  end

  logic [15:0] env_cnt_q, env_pm1;
  logic        env_evt;
  assign env_pm1 = ({regs_q[12], regs_q[11]} == 16'd0) ? 16'd0 : {regs_q[12], regs_q[11]} - 16'd1;
  assign env_evt = tick && (env_cnt_q >= env_pm1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             env_cnt_q <= '0;
    else if (env_restart_q) env_cnt_q <= '0;
    else if (tick)          env_cnt_q <= (env_cnt_q >= env_pm1) ? 16'd0 : env_cnt_q + 16'd1;
  end

  env_state_e    env_state_q, env_state_d;
  logic [EB-1:0] env_step_q, env_step_d, env_hold_q, env_hold_d, env_val;
  logic          env_dir_q, env_dir_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_state_q <= ENV_HOLD;
      env_step_q  <= '0;
      env_hold_q  <= '0;
      env_dir_q   <= 1'b0;
    end else begin
      env_state_q <= env_state_d;
      env_step_q  <= env_step_d;
      env_hold_q  <= env_hold_d;
      env_dir_q   <= env_dir_d;
    end
  end

  // R13 bits: [3] continue, [2] attack, [1] alternate, [0] hold.
  always_comb begin
    env_state_d = env_state_q;
    env_step_d  = env_step_q;
    env_hold_d  = env_hold_q;
    env_dir_d   = env_dir_q;
    if (env_restart_q) begin
      env_state_d = ENV_RUN;
      env_step_d  = '0;
      env_dir_d   = regs_q[13][2];
    end else if (env_state_q == ENV_RUN && env_evt) begin
      if (env_step_q != ENV_MAX) begin
        env_step_d = env_step_q + 1'b1;
      end else if (!regs_q[13][3]) begin
        env_state_d = ENV_HOLD;
        env_hold_d  = '0;
      end else if (regs_q[13][0]) begin
        env_state_d = ENV_HOLD;
        env_hold_d  = (env_dir_q ^ regs_q[13][1]) ? ENV_MAX : '0;
      end else begin
        env_step_d = '0;
        if (regs_q[13][1]) env_dir_d = ~env_dir_q;
      end
    end
  end

  assign env_val = (env_state_q == ENV_HOLD) ? env_hold_q
                 : (env_dir_q ? env_step_q : ENV_MAX - env_step_q);

  logic [COB-1:0] vol [NUM_CHANNELS];

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic [11:0]   per, pm1, cnt_q;
    logic          tone_q, ch_on;
    logic [EB-1:0] fixed_lvl, lvl, shamt;

    assign per = {regs_q[2*i+1][3:0], regs_q[2*i]};
    assign pm1 = (per == 12'd0) ? 12'd0 : per - 12'd1;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        tone_q <= 1'b0;
      end else if (tick) begin
        if (cnt_q >= pm1) begin
          cnt_q  <= '0;
          tone_q <= ~tone_q;
        end else begin
          cnt_q <= cnt_q + 12'd1;
        end
      end
    end

    if (EB == 4) begin : g_lvl4
      assign fixed_lvl = regs_q[8+i][3:0];
    end else begin : g_lvl5
      assign fixed_lvl = (regs_q[8+i][3:0] == 4'd0) ? '0 : EB'({regs_q[8+i][3:0], 1'b1});
    end

    assign lvl    = regs_q[8+i][4] ? env_val : fixed_lvl;
    assign shamt  = (ENV_MAX - lvl) >> (EB - 3);
    assign ch_on  = (regs_q[7][i] | tone_q) & (regs_q[7][3+i] | noise);
    assign vol[i] = (!ch_on || lvl == '0) ? '0 : (FULL >> shamt);
  end

  logic [SW-1:0]  sum;
  logic [COB-1:0] sat;
  logic [MOB-1:0] master_q, pcnt_q;
  logic           pwm_q;

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) sum = sum + SW'(vol[i]);
    sat = (sum > SW'(FULL)) ? FULL : sum[COB-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      master_q <= '0;
      pcnt_q   <= '0;
      pwm_q    <= 1'b0;
    end else begin
      master_q <= sat[COB-1 -: MOB];
      pcnt_q   <= pcnt_q + 1'b1;
      pwm_q    <= (pcnt_q < master_q);
    end
  end

  assign master  = master_q;
  assign pwm_out = pwm_q;
endmodule

// File: tb/tb_psg_ay38910_core.sv
// Scoreboard bench for psg_ay38910_core: tone, bus decode, noise, envelope shapes,
// mixer saturation, PWM duty and asynchronous reset.
`timescale 1ns/1ps
module tb_psg_ay38910_core;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = 8'h00;
  logic       bdir = 1'b0;
  logic       bc1 = 1'b0;
  logic [7:0] master;
  logic       pwm_out;

  int checks = 0;
  int failures = 0;
  int edge_cnt;
  int wr_edge;
  logic [31:0] exp_q[$];
  int vol_tab [16];

  psg_ay38910_core dut (
    .clk(clk), .rst_n(rst_n), .data(data), .bdir(bdir), .bc1(bc1),
    .master(master), .pwm_out(pwm_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks (all start and end on a falling edge)
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic bus_latch(input logic [7:0] a);
    @(negedge clk);
    bdir = 1'b1; bc1 = 1'b1; data = a;
    @(negedge clk);
    bdir = 1'b0; bc1 = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] d);
    @(negedge clk);
    bdir = 1'b1; bc1 = 1'b0; data = d;
    wr_edge = edge_cnt + 1;
    @(negedge clk);
    bdir = 1'b0;
  endtask

  task automatic set_reg(input logic [7:0] a, input logic [7:0] d);
    bus_latch(a);
    bus_write(d);
  endtask

  task automatic wait_edge(input int target);
    while (edge_cnt < target) @(negedge clk);
  endtask

  task automatic measure_toggle(output int cyc);
    logic [7:0] prev;
    prev = master;
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (master !== prev) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic window(input int n, output int mx, output int mn);
    mx = 0; mn = 255;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (int'(master) > mx) mx = int'(master);
      if (int'(master) < mn) mn = int'(master);
    end
  endtask

  task automatic pwm_high_count(output int hi);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (pwm_out === 1'b1) hi++;
    end
  endtask

  // Closed-form envelope level after j step events following an R13 write.
  function automatic int env_ref(input logic [7:0] shape, input int j);
    int s;
    logic dir;
    s = j % 16;
    if (j < 16) return shape[2] ? j : 15 - j;
    if (!shape[3]) return 0;
    if (shape[0]) return (shape[2] ^ shape[1]) ? 15 : 0;
    dir = shape[1] ? (shape[2] ^ ((j / 16) % 2 == 1)) : shape[2];
    return dir ? s : 15 - s;
  endfunction

  task automatic env_run(input string tag, input logic [7:0] shape, input int n);
    int t1;
    set_reg(8'd13, shape);
    t1 = ((wr_edge + 1) / 8 + 1) * 8;
    for (int j = 0; j < n; j++) exp_q.push_back(vol_tab[env_ref(shape, j)]);
    for (int j = 0; j < n; j++) begin
      wait_edge(j == 0 ? t1 : t1 + 8 * j - 4);
      check_eq(tag, master, exp_q.pop_front());
    end
  endtask

  initial begin
    int c, mx, mn, hi;
    logic [16:0] lfsr;
    vol_tab = '{0, 1, 3, 3, 7, 7, 15, 15, 31, 31, 63, 63, 127, 127, 255, 255};

    // reset state
    @(negedge clk);
    check_eq("reset_master", master, 0);
    check_eq("reset_pwm", pwm_out, 0);
    do_reset();

    // tone A, P=5 -> toggle every 40 clk
    set_reg(8'd0, 8'h05);
    set_reg(8'd1, 8'h00);
    set_reg(8'd7, 8'h3E);
    set_reg(8'd8, 8'h0F);
    measure_toggle(c);
    for (int k = 0; k < 3; k++) exp_q.push_back(40);
    for (int k = 0; k < 3; k++) begin
      measure_toggle(c);
      check_eq("tone_half_period", c, exp_q.pop_front());
    end

    // latch with wrong upper nibble: write lands in R8, not R7
    bus_latch(8'h17);
    bus_write(8'hAA);
    exp_q.push_back(63); exp_q.push_back(0);
    window(100, mx, mn);
    check_eq("bad_latch_max", mx, exp_q.pop_front());
    check_eq("bad_latch_min", mn, exp_q.pop_front());

    // bc1-only read and idle cycles must not latch
    @(negedge clk);
    bc1 = 1'b1; data = 8'h07;
    repeat (2) @(negedge clk);
    bc1 = 1'b0;
    @(negedge clk);
    bus_write(8'h0F);
    exp_q.push_back(255); exp_q.push_back(0);
    window(100, mx, mn);
    check_eq("bc1_only_max", mx, exp_q.pop_front());
    check_eq("bc1_only_min", mn, exp_q.pop_front());

    // tone period 0 behaves as 1
    set_reg(8'd0, 8'h00);
    measure_toggle(c);
    for (int k = 0; k < 2; k++) exp_q.push_back(8);
    for (int k = 0; k < 2; k++) begin
      measure_toggle(c);
      check_eq("tone_p0_half_period", c, exp_q.pop_front());
    end

    // noise on A only; LFSR shifts every tick from reset
    do_reset();
    set_reg(8'd7, 8'h37);
    set_reg(8'd8, 8'h0F);
    set_reg(8'd6, 8'h01);
    lfsr = 17'h1;
    for (int m = 0; m <= 60; m++) begin
      if (m >= 3) exp_q.push_back(lfsr[0] ? 255 : 0);
      lfsr = {lfsr[0] ^ lfsr[3], lfsr[16:1]};
    end
    for (int m = 3; m <= 60; m++) begin
      wait_edge(8 * m + 4);
      check_eq("noise_seq", master, exp_q.pop_front());
    end

    // envelope shapes on A
    set_reg(8'd7, 8'h3F);
    set_reg(8'd8, 8'h10);
    set_reg(8'd11, 8'h01);
    set_reg(8'd12, 8'h00);
    env_run("env_0e_triangle", 8'h0E, 40);
    env_run("env_0d_up_hold", 8'h0D, 22);
    env_run("env_09_down_hold0", 8'h09, 20);
    env_run("env_0b_down_holdmax", 8'h0B, 20);
    env_run("env_00_single_decay", 8'h00, 20);
    env_run("env_restart_a", 8'h0D, 6);
    env_run("env_restart_b", 8'h0D, 6);

    // mixer: three full channels saturate
    set_reg(8'd7, 8'h3F);
    set_reg(8'd8, 8'h0F);
    set_reg(8'd9, 8'h0F);
    set_reg(8'd10, 8'h0F);
    repeat (4) @(negedge clk);
    exp_q.push_back(255); exp_q.push_back(255);
    check_eq("mix_saturate", master, exp_q.pop_front());
    pwm_high_count(hi);
    check_eq("pwm_full_duty", hi, exp_q.pop_front());

    // unsaturated sum 127+127
    set_reg(8'd8, 8'h0D);
    set_reg(8'd9, 8'h0D);
    set_reg(8'd10, 8'h00);
    repeat (4) @(negedge clk);
    exp_q.push_back(254); exp_q.push_back(254);
    check_eq("mix_sum", master, exp_q.pop_front());
    pwm_high_count(hi);
    check_eq("pwm_duty_254", hi, exp_q.pop_front());

    // reset in the middle of an envelope ramp
    set_reg(8'd8, 8'h10);
    set_reg(8'd13, 8'h0E);
    repeat (60) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_master", master, 0);
    check_eq("async_reset_pwm", pwm_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("post_reset_master", master, 0);
    check_eq("post_reset_pwm", pwm_out, 0);

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
